uart_imem_loader_wrapper: RTL and testbench

//  Top-level boot-load wrapper. Receives 8N1 UART bytes and packs them little-endian into
//  32-bit words. Writes the words sequentially into an on-chip instruction RAM.

---
 rtl/uart_imem_loader_wrapper.sv | 193 +++++++++++++++++++
 tb/tb_uart_imem_loader_wrapper.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_imem_loader_wrapper.sv
// Boot-load wrapper: 8N1 UART receiver feeding a little-endian word packer that fills an
// instruction RAM until the 0xFFFFFFFF terminator (or a full RAM), then opens the GPIO port.
`timescale 1ns/1ps

module uart_imem_loader_wrapper #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BIT_RATE   = 9600,
    parameter int IMEM_WORDS = 256
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       uart_rxd,
    input  logic       uart_rx_en,
    output logic       uart_rx_break,
    output logic       uart_rx_valid,
    output logic [7:0] uart_rx_data,
    input  logic [3:0] input_gpio_pins,
    output logic [3:0] output_gpio_pins,
    output logic       write_done
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
    localparam int ADDR_W         = (IMEM_WORDS > 1) ? $clog2(IMEM_WORDS) : 1;
    localparam int PTR_W          = ADDR_W + 1;

    localparam logic [CNT_W-1:0] FULL_BIT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_BIT_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [PTR_W-1:0] PTR_FULL      = PTR_W'(IMEM_WORDS);

    // Handshake: uart_rx_valid is a single-cycle strobe with no back-pressure; uart_rx_data is
    // stable during the strobe and held until the next frame's 8th data bit is sampled.

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state;
    logic             rxd_meta;
    logic             rxd_sync;
    logic             rxd_prev;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       rx_shift;

    logic [23:0]      word_reg;
    logic [1:0]       byte_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      full_word;
    logic             load_byte;
    logic             ram_full;
    logic             word_commit;

    logic [31:0]      imem [IMEM_WORDS];

    // Idle-high reset value keeps the edge detector from seeing a false start after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_state      <= RX_IDLE;
            bit_cnt       <= '0;
            bit_idx       <= '0;
            rx_shift      <= '0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            if (!uart_rx_en) begin
                rx_state <= RX_IDLE;
                bit_cnt  <= '0;
                bit_idx  <= '0;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        bit_cnt <= '0;
                        if (rxd_prev && !rxd_sync) begin
                            rx_state <= RX_START;
                        end
                    end
                    RX_START: begin
                        if (bit_cnt == HALF_BIT_LAST) begin
                            bit_cnt  <= '0;
                            bit_idx  <= '0;
                            rx_state <= rxd_sync ? RX_IDLE : RX_DATA;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    RX_DATA: begin
                        if (bit_cnt == FULL_BIT_LAST) begin
                            bit_cnt  <= '0;
                            rx_shift <= {rxd_sync, rx_shift[7:1]};
                            if (bit_idx == 3'd7) begin
                                uart_rx_data <= {rxd_sync, rx_shift[7:1]};
                                rx_state     <= RX_STOP;
                            end else begin
                                bit_idx <= bit_idx + 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    RX_STOP: begin
                        if (bit_cnt == FULL_BIT_LAST) begin
                            bit_cnt  <= '0;
                            rx_state <= RX_IDLE;
                            if (rxd_sync) begin
                                uart_rx_valid <= 1'b1;
                            end else if (uart_rx_data == 8'h00) begin
                                uart_rx_break <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    // The 4th byte is merged combinationally so the word commits in the cycle it arrives.
    always_comb begin
        full_word   = {uart_rx_data, word_reg};
        load_byte   = uart_rx_valid && !write_done;
        ram_full    = (wr_ptr == PTR_FULL);
        word_commit = load_byte && (byte_cnt == 2'd3) && (full_word != 32'hFFFF_FFFF) && !ram_full;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_reg   <= '0;
            byte_cnt   <= '0;
            wr_ptr     <= '0;
            write_done <= 1'b0;
        end else begin
            if (uart_rx_break) begin
                byte_cnt <= '0;
            end else if (load_byte) begin
                byte_cnt <= byte_cnt + 1'b1;
                case (byte_cnt)
                    2'd0: word_reg[7:0]   <= uart_rx_data;
                    2'd1: word_reg[15:8]  <= uart_rx_data;
                    2'd2: word_reg[23:16] <= uart_rx_data;
                    default: begin
                        if (full_word == 32'hFFFF_FFFF) begin
                            write_done <= 1'b1;
                        end
                    end
                endcase
            end
            if (word_commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (ram_full) begin
                write_done <= 1'b1;
            end
        end
    end

    // RAM is deliberately left out of reset so a reload overwrites only what is resent.
    always_ff @(posedge clk) begin
        if (word_commit) begin
            imem[wr_ptr[ADDR_W-1:0]] <= full_word;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            output_gpio_pins <= '0;
        end else begin
            output_gpio_pins <= write_done ? input_gpio_pins : 4'b0000;
        end
    end

endmodule

// File: tb/tb_uart_imem_loader_wrapper.sv
// Directed bench for uart_imem_loader_wrapper: UART frames are driven bit by bit at a short
// bit period (16 clocks) and received bytes, RAM words and GPIO behaviour are compared.
`timescale 1ns/1ps

module tb_uart_imem_loader_wrapper;

    localparam int CLK_HZ     = 50_000_000;
    localparam int BIT_RATE   = 3_125_000;
    localparam int IMEM_WORDS = 8;
    localparam int CPB        = CLK_HZ / BIT_RATE;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       uart_rxd = 1'b1;
    logic       uart_rx_en = 1'b0;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic [3:0] input_gpio_pins = 4'b0000;
    logic [3:0] output_gpio_pins;
    logic       write_done;

    int assert_cnt = 0;
    int fail_cnt   = 0;
    int valid_cnt  = 0;
    int break_cnt  = 0;
    logic [7:0] exp_q[$];

    logic [31:0] full_tbl [8];

    uart_imem_loader_wrapper #(
        .CLK_HZ    (CLK_HZ),
        .BIT_RATE  (BIT_RATE),
        .IMEM_WORDS(IMEM_WORDS)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .uart_rxd        (uart_rxd),
        .uart_rx_en      (uart_rx_en),
        .uart_rx_break   (uart_rx_break),
        .uart_rx_valid   (uart_rx_valid),
        .uart_rx_data    (uart_rx_data),
        .input_gpio_pins (input_gpio_pins),
        .output_gpio_pins(output_gpio_pins),
        .write_done      (write_done)
    );

    // clock block
    always #10 clk = ~clk;

    // scoreboard: every valid strobe must carry the next expected byte
    always @(negedge clk) begin
        if (resetn && uart_rx_valid) begin
            valid_cnt++;
            assert_cnt++;
            if (exp_q.size() == 0) begin
                fail_cnt++;
                $display("FAIL unexpected_valid: got byte %h, expected no valid", uart_rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (uart_rx_data !== e) begin
                    fail_cnt++;
                    $display("FAIL rx_byte: got %h expected %h", uart_rx_data, e);
                end
            end
        end
        if (resetn && uart_rx_break) break_cnt++;
    end

    // driver tasks
    task automatic apply_reset();
        resetn   = 1'b0;
        uart_rxd = 1'b1;
        exp_q.delete();
        repeat (200) @(posedge clk);
        resetn = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int drop_bit,
                              output logic [7:0] data_at_stop);
        uart_rxd = 1'b0;
        if (drop_bit == 0) uart_rx_en = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            if (drop_bit == i + 1) uart_rx_en = 1'b0;
            uart_rxd = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rxd = stop_bit;
        #1 data_at_stop = uart_rx_data;
        repeat (CPB) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [7:0] d;
        exp_q.push_back(b);
        send_frame(b, 1'b1, -1, d);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic test_reset();
        input_gpio_pins = 4'b0111;
        resetn = 1'b0;
        repeat (200) @(posedge clk);
        @(negedge clk);
        assert_cnt++; if (uart_rx_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_valid: got %b expected 0", uart_rx_valid); end
        assert_cnt++; if (uart_rx_break !== 1'b0) begin fail_cnt++; $display("FAIL reset_break: got %b expected 0", uart_rx_break); end
        assert_cnt++; if (uart_rx_data !== 8'h00) begin fail_cnt++; $display("FAIL reset_data: got %h expected 00", uart_rx_data); end
        assert_cnt++; if (output_gpio_pins !== 4'b0000) begin fail_cnt++; $display("FAIL reset_gpio: got %b expected 0000", output_gpio_pins); end
        assert_cnt++; if (write_done !== 1'b0) begin fail_cnt++; $display("FAIL reset_done: got %b expected 0", write_done); end
        assert_cnt++; if (dut.wr_ptr !== 4'd0) begin fail_cnt++; $display("FAIL reset_wr_ptr: got %0d expected 0", dut.wr_ptr); end
        assert_cnt++; if (dut.byte_cnt !== 2'd0) begin fail_cnt++; $display("FAIL reset_byte_cnt: got %0d expected 0", dut.byte_cnt); end
        resetn = 1'b1;
        input_gpio_pins = 4'b0000;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] d;
        int v0;
        uart_rx_en = 1'b1;
        v0 = valid_cnt;
        exp_q.push_back(8'h93);
        send_frame(8'h93, 1'b1, -1, d);
        @(negedge clk);
        assert_cnt++; if (d !== 8'h93) begin fail_cnt++; $display("FAIL single_data_at_stop: got %h expected 93", d); end
        assert_cnt++; if (valid_cnt - v0 != 1) begin fail_cnt++; $display("FAIL single_valid_count: got %0d expected 1", valid_cnt - v0); end
        assert_cnt++; if (write_done !== 1'b0) begin fail_cnt++; $display("FAIL single_done: got %b expected 0", write_done); end
        assert_cnt++; if (dut.byte_cnt !== 2'd1) begin fail_cnt++; $display("FAIL single_byte_cnt: got %0d expected 1", dut.byte_cnt); end
    endtask

    task automatic test_word();
        logic [7:0] bytes_tbl [4];
        logic [7:0] d;
        bytes_tbl = '{8'h13, 8'h01, 8'h01, 8'hfc};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(bytes_tbl[i]);
            send_frame(bytes_tbl[i], 1'b1, -1, d);
            assert_cnt++; if (d !== bytes_tbl[i]) begin fail_cnt++; $display("FAIL word_byte%0d: got %h expected %h", i, d, bytes_tbl[i]); end
        end
        @(negedge clk);
        assert_cnt++; if (dut.imem[0] !== 32'hfc010113) begin fail_cnt++; $display("FAIL word_imem0: got %h expected fc010113", dut.imem[0]); end
        assert_cnt++; if (dut.wr_ptr !== 4'd1) begin fail_cnt++; $display("FAIL word_wr_ptr: got %0d expected 1", dut.wr_ptr); end
        assert_cnt++; if (dut.byte_cnt !== 2'd0) begin fail_cnt++; $display("FAIL word_byte_cnt: got %0d expected 0", dut.byte_cnt); end
    endtask

    task automatic test_ram_full();
        int v0;
        full_tbl = '{32'h0000_0001, 32'h1234_5678, 32'hA5A5_5A5A, 32'hC0DE_CAFE,
                     32'h0BAD_F00D, 32'hFFFF_FFFE, 32'h8000_0000, 32'h7654_3210};
        apply_reset();
        for (int i = 0; i < 8; i++) send_word(full_tbl[i]);
        @(negedge clk);
        assert_cnt++; if (write_done !== 1'b1) begin fail_cnt++; $display("FAIL full_done: got %b expected 1", write_done); end
        assert_cnt++; if (dut.wr_ptr !== 4'd8) begin fail_cnt++; $display("FAIL full_wr_ptr: got %0d expected 8", dut.wr_ptr); end
        for (int i = 0; i < 8; i++) begin
            assert_cnt++; if (dut.imem[i] !== full_tbl[i]) begin fail_cnt++; $display("FAIL full_imem%0d: got %h expected %h", i, dut.imem[i], full_tbl[i]); end
        end
        v0 = valid_cnt;
        send_word(32'hDEAD_BEEF);
        @(negedge clk);
        assert_cnt++; if (valid_cnt - v0 != 4) begin fail_cnt++; $display("FAIL full_still_reported: got %0d expected 4", valid_cnt - v0); end
        assert_cnt++; if (dut.wr_ptr !== 4'd8) begin fail_cnt++; $display("FAIL full_no_wrap: got %0d expected 8", dut.wr_ptr); end
        assert_cnt++; if (dut.imem[0] !== full_tbl[0]) begin fail_cnt++; $display("FAIL full_no_overwrite: got %h expected %h", dut.imem[0], full_tbl[0]); end
    endtask

    task automatic test_terminator_gpio();
        logic [31:0] t_tbl [3];
        logic [7:0]  d;
        int n;
        t_tbl = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
        apply_reset();
        input_gpio_pins = 4'b0111;
        for (int i = 0; i < 3; i++) send_word(t_tbl[i]);
        for (int i = 0; i < 3; i++) send_byte(8'hFF);
        @(negedge clk);
        assert_cnt++; if (write_done !== 1'b0) begin fail_cnt++; $display("FAIL term_done_early: got %b expected 0", write_done); end
        assert_cnt++; if (output_gpio_pins !== 4'b0000) begin fail_cnt++; $display("FAIL term_gpio_before: got %b expected 0000", output_gpio_pins); end
        exp_q.push_back(8'hFF);
        n = 0;
        fork
            send_frame(8'hFF, 1'b1, -1, d);
            begin
                while (write_done !== 1'b1 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                assert_cnt++; if (write_done !== 1'b1) begin fail_cnt++; $display("FAIL term_done_timeout: got %b expected 1", write_done); end
                assert_cnt++; if (output_gpio_pins !== 4'b0000) begin fail_cnt++; $display("FAIL term_gpio_same_clk: got %b expected 0000", output_gpio_pins); end
                @(negedge clk);
                assert_cnt++; if (output_gpio_pins !== 4'b0111) begin fail_cnt++; $display("FAIL term_gpio_live: got %b expected 0111", output_gpio_pins); end
                input_gpio_pins = 4'b0000;
                @(negedge clk);
                assert_cnt++; if (output_gpio_pins !== 4'b0000) begin fail_cnt++; $display("FAIL term_gpio_follow: got %b expected 0000", output_gpio_pins); end
            end
        join
        @(negedge clk);
        assert_cnt++; if (dut.wr_ptr !== 4'd3) begin fail_cnt++; $display("FAIL term_wr_ptr: got %0d expected 3", dut.wr_ptr); end
        for (int i = 0; i < 3; i++) begin
            assert_cnt++; if (dut.imem[i] !== t_tbl[i]) begin fail_cnt++; $display("FAIL term_imem%0d: got %h expected %h", i, dut.imem[i], t_tbl[i]); end
        end
        assert_cnt++; if (dut.imem[3] !== full_tbl[3]) begin fail_cnt++; $display("FAIL term_imem3_kept: got %h expected %h", dut.imem[3], full_tbl[3]); end
    endtask

    task automatic test_break_resync();
        logic [7:0] d;
        int v0;
        int b0;
        apply_reset();
        v0 = valid_cnt;
        b0 = break_cnt;
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_frame(8'h00, 1'b0, -1, d);
        send_word(32'h1122_3344);
        @(negedge clk);
        assert_cnt++; if (break_cnt - b0 != 1) begin fail_cnt++; $display("FAIL brk_count: got %0d expected 1", break_cnt - b0); end
        assert_cnt++; if (valid_cnt - v0 != 6) begin fail_cnt++; $display("FAIL brk_valid_count: got %0d expected 6", valid_cnt - v0); end
        assert_cnt++; if (dut.imem[0] !== 32'h1122_3344) begin fail_cnt++; $display("FAIL brk_imem0: got %h expected 11223344", dut.imem[0]); end
        assert_cnt++; if (dut.wr_ptr !== 4'd1) begin fail_cnt++; $display("FAIL brk_wr_ptr: got %0d expected 1", dut.wr_ptr); end
    endtask

    task automatic test_extra();
        logic [7:0] d;
        int v0;
        int b0;
        apply_reset();
        send_byte(8'h5C);
        v0 = valid_cnt;
        send_frame(8'hA5, 1'b1, 3, d);
        repeat (2 * CPB) @(posedge clk);
        uart_rx_en = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        assert_cnt++; if (valid_cnt != v0) begin fail_cnt++; $display("FAIL en_drop_valid: got %0d expected 0", valid_cnt - v0); end
        assert_cnt++; if (uart_rx_data !== 8'h5C) begin fail_cnt++; $display("FAIL en_drop_data: got %h expected 5c", uart_rx_data); end
        assert_cnt++; if (dut.byte_cnt !== 2'd1) begin fail_cnt++; $display("FAIL en_drop_byte_cnt: got %0d expected 1", dut.byte_cnt); end

        b0 = break_cnt;
        uart_rxd = 1'b0;
        repeat (CPB / 2 - 1) @(posedge clk);
        uart_rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        assert_cnt++; if (valid_cnt != v0 || break_cnt != b0) begin fail_cnt++; $display("FAIL glitch_pulses: got %0d/%0d expected 0/0", valid_cnt - v0, break_cnt - b0); end
        send_byte(8'h3E);
        @(negedge clk);
        assert_cnt++; if (dut.byte_cnt !== 2'd2) begin fail_cnt++; $display("FAIL glitch_recover: got %0d expected 2", dut.byte_cnt); end

        v0 = valid_cnt;
        send_frame(8'h5A, 1'b0, -1, d);
        @(negedge clk);
        assert_cnt++; if (valid_cnt != v0 || break_cnt != b0) begin fail_cnt++; $display("FAIL framing_pulses: got %0d/%0d expected 0/0", valid_cnt - v0, break_cnt - b0); end
        assert_cnt++; if (dut.byte_cnt !== 2'd2) begin fail_cnt++; $display("FAIL framing_byte_cnt: got %0d expected 2", dut.byte_cnt); end

        resetn = 1'b0;
        @(negedge clk);
        assert_cnt++; if (uart_rx_data !== 8'h00) begin fail_cnt++; $display("FAIL midword_reset_data: got %h expected 00", uart_rx_data); end
        assert_cnt++; if (dut.byte_cnt !== 2'd0) begin fail_cnt++; $display("FAIL midword_reset_byte_cnt: got %0d expected 0", dut.byte_cnt); end
        assert_cnt++; if (output_gpio_pins !== 4'b0000 || write_done !== 1'b0) begin fail_cnt++; $display("FAIL midword_reset_outs: got %b/%b expected 0000/0", output_gpio_pins, write_done); end
        repeat (4) @(posedge clk);
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        send_word(32'h0BAD_F00D);
        @(negedge clk);
        assert_cnt++; if (dut.imem[0] !== 32'h0BAD_F00D) begin fail_cnt++; $display("FAIL midword_restart_imem0: got %h expected 0badf00d", dut.imem[0]); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_word();
        test_ram_full();
        test_terminator_gpio();
        test_break_resync();
        test_extra();
        repeat (10) @(posedge clk);
        assert_cnt++;
        if (exp_q.size() != 0) begin
            fail_cnt++;
            $display("FAIL sb_drain: got %0d bytes outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
